adc_conversion_controller: RTL and testbench
============================================

Name: adc_conversion_controller

Overview:
Sequences the delta sigma modulator and decimates its serial bitstream into parallel result words. Gates the modulator on and off, discards a configurable number of settling windows, then counts ones over each OSR-cycle window to produce a RESULT_WIDTH-bit sample. Supports single-shot and continuous conversion. Results go to the consumer through a one-deep valid/ready output register with sticky overrun reporting.

Parameters:
OSR, 256, oversampling window length in clk cycles; power of two and at least 2^RESULT_WIDTH
RESULT_WIDTH, 8, result word width
SETTLE_WINDOWS, 2, full windows discarded after each start; 0 allowed

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin conversion; acted on only in IDLE
stop  in  1  abort activity and return to IDLE
continuous  in  1  1 = run back-to-back windows; 0 = single-shot
adcInput  in  1  modulator output bit
resultReady  in  1  consumer accepts resultData
overrunClear  in  1  clears overrun
modulatorEnable  out  1  enables the modulator
resultData  out  RESULT_WIDTH  decimated sample
resultValid  out  1  resultData holds an unconsumed sample
busy  out  1  state is not IDLE
overrun  out  1  sticky; an unconsumed result was overwritten

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all counters 0; modulatorEnable, resultData, resultValid, busy and overrun all 0.
- State IDLE: modulatorEnable=0, busy=0.
  - start=1 and stop=0 at an edge: go to SETTLE (or CONVERT if SETTLE_WINDOWS=0).
  - modulatorEnable and busy go to 1 after that same edge.
- State SETTLE: sample adcInput every edge; discard all samples.
  - Leave after SETTLE_WINDOWS*OSR edges and go to CONVERT with window counter 0.
- State CONVERT: window counter runs 0..OSR-1; each edge adds adcInput to the ones accumulator.
  - Accumulator width is log2(OSR)+1.
  - At the edge where counter=OSR-1, form the final count including that sample.
  - result = (count >> (log2(OSR)-RESULT_WIDTH)), saturated to 2^RESULT_WIDTH-1 (all-ones input gives max code).
  - The result loads into resultData and resultValid=1 after that edge.
  - On the same edge, sample continuous:
    - continuous=1: next window starts immediately. Counter goes to 0 and the accumulator takes the next sample on the following edge. No gap cycles.
    - continuous=0: go to IDLE; modulatorEnable and busy drop after that edge.
- Latency: for start sampled at edge E0, resultValid rises after edge E0+(SETTLE_WINDOWS+1)*OSR. With defaults that is 768 cycles. Each later continuous result follows OSR cycles after the previous one.
- Handshake: a transfer occurs on an edge with resultValid=1 and resultReady=1.
  - resultValid stays high and resultData stays stable until a transfer.
  - resultReady has no effect when resultValid=0.
- New result with the output register occupied:
  - If a transfer happens on the same edge: load the new data, resultValid stays 1, no overrun.
  - Otherwise: overwrite resultData and set overrun=1.
- overrun clearing: overrunClear=1 clears overrun. If a set condition and overrunClear occur on the same edge, set wins.
- stop=1 at any edge in SETTLE or CONVERT:
  - Discard the partial window and go to IDLE.
  - modulatorEnable and busy drop after that edge.
  - A pending resultValid/resultData is retained.
- Simultaneous events:
  - stop and start in the same edge in IDLE: stop wins, stay IDLE.
  - start while busy is ignored.
  - stop on the final edge of a window: stop wins and no result is produced.
- Reset mid-conversion: immediate return to reset values, including loss of any pending result.

Test Plan:
1. Defaults, adcInput=1, continuous=0, pulse start at edge E0 -> resultValid after E0+768, resultData=255, modulatorEnable/busy drop after the same edge, overrun=0.
2. Defaults, adcInput alternating 1,0 from start, resultReady=1 -> resultData=128; resultValid clears one edge after acceptance.
3. Defaults, continuous=1, adcInput=0, resultReady=1 -> results of 0 every 256 cycles after the first at 768, no gaps, overrun stays 0; clearing continuous ends after the current window.
4. Continuous, resultReady=0 -> second result overwrites, overrun=1. overrunClear pulse -> overrun=0. overrunClear coincident with a third overwrite -> overrun stays 1.
5. stop at CONVERT cycle 100 -> modulatorEnable=0 next cycle, no new resultValid, old pending result retained. start+stop together in IDLE -> busy stays 0.
6. rst driven low mid-CONVERT with resultValid=1 -> all outputs 0 immediately. After release, start behaves as in scenario 1.

Source files
------------

// File: rtl/adc_conversion_controller.sv
// rtl/adc_conversion_controller.sv - delta-sigma modulator sequencer and ones-count decimator
module adc_conversion_controller #(
    parameter int OSR            = 256,
    parameter int RESULT_WIDTH   = 8,
    parameter int SETTLE_WINDOWS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic                    adcInput,
    input  logic                    resultReady,
    input  logic                    overrunClear,
    output logic                    modulatorEnable,
    output logic [RESULT_WIDTH-1:0] resultData,
    output logic                    resultValid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int LOG2_OSR = $clog2(OSR);
    localparam int AW       = LOG2_OSR + 1;
    localparam int SHIFT    = LOG2_OSR - RESULT_WIDTH;
    localparam int WW       = (SETTLE_WINDOWS > 1) ? $clog2(SETTLE_WINDOWS) : 1;

    localparam logic [AW-1:0] MAX_CODE = AW'((1 << RESULT_WIDTH) - 1);
    localparam logic [WW-1:0] LAST_WIN = WW'((SETTLE_WINDOWS > 0) ? SETTLE_WINDOWS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [LOG2_OSR-1:0]     cnt;
    logic [WW-1:0]           win;
    logic [AW-1:0]           acc;
    logic [AW-1:0]           count;
    logic [AW-1:0]           scaled;
    logic [RESULT_WIDTH-1:0] result;
    logic                    window_end;
    logic                    last_settle;
    logic                    load;

    // OSR is a power of two, so the window counter wraps on its own
    assign window_end  = &cnt;
    assign last_settle = window_end && (win == LAST_WIN);
    assign count       = acc + AW'(adcInput);
    assign scaled      = count >> SHIFT;
    assign result      = (scaled > MAX_CODE) ? '1 : scaled[RESULT_WIDTH-1:0];
    assign load        = (state == CONVERT) && window_end && !stop;

    always_comb begin
        state_d         = state;
        modulatorEnable = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (SETTLE_WINDOWS == 0) state_d = CONVERT;
                    else                     state_d = SETTLE;
                end
            end
            SETTLE: begin
                modulatorEnable = 1'b1;
                busy            = 1'b1;
                if (stop)             state_d = IDLE;
                else if (last_settle) state_d = CONVERT;
            end
            CONVERT: begin
                modulatorEnable = 1'b1;
                busy            = 1'b1;
                if (stop)                           state_d = IDLE;
                else if (window_end && !continuous) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            win         <= '0;
            acc         <= '0;
            resultData  <= '0;
            resultValid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state <= state_d;

            if (state == IDLE || stop) begin
                cnt <= '0;
                win <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (state == SETTLE) begin
                    if (window_end) win <= last_settle ? '0 : win + 1'b1;
                end else begin
                    acc <= window_end ? '0 : count;
                end
            end

            // A same-edge transfer frees the register, so the new sample is not an overrun
            if (load) begin
                resultData  <= result;
                resultValid <= 1'b1;
            end else if (resultValid && resultReady) begin
                resultValid <= 1'b0;
            end

            if (load && resultValid && !resultReady) overrun <= 1'b1;
            else if (overrunClear)                   overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_conversion_controller.sv
// tb/tb_adc_conversion_controller.sv - scoreboard bench for adc_conversion_controller
module tb_adc_conversion_controller;

    localparam int OSR  = 256;
    localparam int RW   = 8;
    localparam int SW   = 2;
    localparam int MAXC = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, continuous, adcInput, resultReady, overrunClear;
    logic          modulatorEnable, resultValid, busy, overrun;
    logic [RW-1:0] resultData;

    int n_vec  = 0;
    int n_miss = 0;
    int adc_mode = 0;

    adc_conversion_controller #(.OSR(OSR), .RESULT_WIDTH(RW), .SETTLE_WINDOWS(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .adcInput(adcInput), .resultReady(resultReady), .overrunClear(overrunClear),
        .modulatorEnable(modulatorEnable), .resultData(resultData), .resultValid(resultValid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed edges since start, ones counted per window
    bit m_active, m_valid, m_overrun, produce, xfer, set_ov;
    int m_elapsed, m_ones, res;
    int sb_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_valid = 0; m_overrun = 0;
            m_elapsed = 0; m_ones = 0;
            sb_q.delete();
        end else begin
            xfer    = m_valid && resultReady;
            produce = 0;
            if (!m_active) begin
                if (start && !stop) begin
                    m_active = 1; m_elapsed = 0; m_ones = 0;
                end
            end else if (stop) begin
                m_active = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed > SW * OSR) begin
                    m_ones += int'(adcInput);
                    if ((m_elapsed - SW * OSR) % OSR == 0) begin
                        produce = 1;
                        res = m_ones >> ($clog2(OSR) - RW);
                        if (res > MAXC) res = MAXC;
                        m_ones = 0;
                        if (!continuous) m_active = 0;
                    end
                end
            end
            set_ov = produce && m_valid && !xfer;
            if (set_ov)            m_overrun = 1;
            else if (overrunClear) m_overrun = 0;
            if (produce) begin
                if (set_ov && sb_q.size() > 0) void'(sb_q.pop_back());
                sb_q.push_back(res);
                m_valid = 1;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        int exp_d;
        chk("busy", busy, m_active);
        chk("modulatorEnable", modulatorEnable, m_active);
        chk("resultValid", resultValid, m_valid);
        chk("overrun", overrun, m_overrun);
        if (rst && resultValid && resultReady) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL scoreboard_empty: got data %0d expected none", resultData);
            end else begin
                exp_d = sb_q.pop_front();
                chk("resultData", resultData, exp_d);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (adc_mode)
            0: adcInput = 1'b0;
            1: adcInput = ~adcInput;
            2: adcInput = 1'b1;
            default: adcInput = 1'($urandom % 2);
        endcase
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(string name, int exp_lat);
        int lat = 0;
        while (!resultValid && lat < 2000) begin
            step(1);
            lat++;
        end
        chk(name, lat, exp_lat);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 0; stop = 0; continuous = 0; adcInput = 0;
        resultReady = 0; overrunClear = 0;
        step(3);
        chk("reset_resultData", resultData, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;
        step(2);

        // Full-scale single shot
        adc_mode = 2;
        pulse_start();
        wait_valid("latency_single", 768);
        chk("full_scale", resultData, 255);
        step(3);
        chk("idle_after_single", busy, 0);
        resultReady = 1'b1;
        step(2);

        // Alternating input gives mid-scale
        adc_mode = 1;
        pulse_start();
        wait_valid("latency_alt", 768);
        chk("mid_scale", resultData, 128);
        step(1);
        chk("valid_clears", resultValid, 0);

        // Continuous zeros, consumer always ready
        adc_mode = 0;
        continuous = 1'b1;
        pulse_start();
        wait_valid("latency_cont", 768);
        chk("zero_code", resultData, 0);
        step(1);
        wait_valid("cont_period", 255);
        step(OSR * 2);
        continuous = 1'b0;
        step(OSR + 10);
        chk("cont_stopped", busy, 0);

        // Overrun with consumer stalled
        adc_mode = 3;
        resultReady = 1'b0;
        continuous  = 1'b1;
        pulse_start();
        step(768 + OSR + 10);
        chk("overrun_set", overrun, 1);
        overrunClear = 1'b1;
        step(1);
        overrunClear = 1'b0;
        chk("overrun_cleared", overrun, 0);
        overrunClear = 1'b1;
        step(OSR + 10);
        overrunClear = 1'b0;
        continuous = 1'b0;
        step(OSR + 10);

        // Stop mid-convert keeps the pending result
        pulse_start();
        step(SW * OSR + 100);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_modulator", modulatorEnable, 0);
        step(OSR);
        chk("pending_kept", resultValid, 1);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", busy, 0);

        // Reset mid-conversion
        pulse_start();
        step(600);
        rst = 1'b0;
        #1;
        chk("rst_valid", resultValid, 0);
        chk("rst_data", resultData, 0);
        chk("rst_enable", modulatorEnable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        step(2);
        rst = 1'b1;
        step(1);
        adc_mode = 2;
        pulse_start();
        wait_valid("latency_after_rst", 768);
        chk("full_scale_after_rst", resultData, 255);

        // Randomized traffic
        adc_mode = 3;
        for (int i = 0; i < 30000; i++) begin
            start        = ($urandom % 40) == 0;
            stop         = ($urandom % 3000) == 0;
            overrunClear = ($urandom % 200) == 0;
            resultReady  = ($urandom % 3) != 0;
            if (($urandom % 500) == 0) continuous = ~continuous;
            step(1);
        end

        start = 0; overrunClear = 0; continuous = 0;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        resultReady = 1'b1;
        step(3);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
